// File: rtl/gen_fib_pkg.sv
// Shared encodings and seed constants for the iterative linear-recurrence engine.
package gen_fib_pkg;

  typedef enum logic [1:0] {
    MODE_CLASSIC = 2'd0,
    MODE_EXT     = 2'd1,
    MODE_GEN     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic F0 = 1'b0;
  localparam logic F1 = 1'b1;

endpackage

// File: rtl/gen_fib_engine_fib_step.sv
// One combinational recurrence step: c_cur*F(k-1) + c_prev*F(k-2), truncated to RES_W
// with a flag raised when any bit above RES_W is set.
module fib_step
  import gen_fib_pkg::*;
#(
  parameter int N_W    = 5,
  parameter int RES_W  = 121,
  parameter int COEF_W = 8
) (
  input  logic [RES_W-1:0]  f_prev_i,
  input  logic [RES_W-1:0]  f_cur_i,
  input  logic [N_W-1:0]    k_i,
  input  mode_e             mode_i,
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  output logic [RES_W-1:0]  f_next_o,
  output logic              ovf_o
);

  localparam int MW = (COEF_W > N_W) ? COEF_W : N_W;
  localparam int FW = RES_W + MW + 1;

  logic [MW-1:0] c_cur;
  logic [MW-1:0] c_prev;
  logic [FW-1:0] full;

  // Every mode reduces to the same mul-add; only the two coefficients differ.
  always_comb begin
    c_cur  = MW'(1);
    c_prev = MW'(1);
    case (mode_i)
      MODE_EXT: begin
        c_cur  = MW'(k_i - N_W'(1));
        c_prev = MW'(1);
      end
      MODE_GEN: begin
        c_cur  = MW'(a_i);
        c_prev = MW'(b_i);
      end
      default: begin
        c_cur  = MW'(1);
        c_prev = MW'(1);
      end
    endcase
  end

  assign full     = (FW'(c_cur) * FW'(f_cur_i)) + (FW'(c_prev) * FW'(f_prev_i));
  assign f_next_o = full[RES_W-1:0];
  assign ovf_o    = |full[FW-1:RES_W];

endmodule

// File: rtl/gen_fib_engine.sv
// Iterative recurrence engine: one step per clock behind a start/done handshake,
// with sticky per-operation overflow and a reserved-mode error flag.
module gen_fib_engine
  import gen_fib_pkg::*;
#(
  parameter int N_W    = 5,
  parameter int RES_W  = 121,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  input  logic [1:0]        mode,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  ans,
  output logic              overflow,
  output logic              mode_err
);

  state_e              state_q, state_d;
  logic [N_W-1:0]      n_q, n_d;
  mode_e               mode_q, mode_d;
  logic [COEF_W-1:0]   a_q, a_d;
  logic [COEF_W-1:0]   b_q, b_d;
  logic [N_W-1:0]      k_q, k_d;
  logic [RES_W-1:0]    f_prev_q, f_prev_d;
  logic [RES_W-1:0]    f_cur_q, f_cur_d;
  logic [RES_W-1:0]    ans_q, ans_d;
  logic                ovf_q, ovf_d;
  logic                merr_q, merr_d;

  logic [RES_W-1:0]    step_f;
  logic                step_ovf;

  fib_step #(
    .N_W    (N_W),
    .RES_W  (RES_W),
    .COEF_W (COEF_W)
  ) u_step (
    .f_prev_i (f_prev_q),
    .f_cur_i  (f_cur_q),
    .k_i      (k_q),
    .mode_i   (mode_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .f_next_o (step_f),
    .ovf_o    (step_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      mode_q   <= MODE_CLASSIC;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      f_prev_q <= '0;
      f_cur_q  <= '0;
      ans_q    <= '0;
      ovf_q    <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      f_prev_q <= f_prev_d;
      f_cur_q  <= f_cur_d;
      ans_q    <= ans_d;
      ovf_q    <= ovf_d;
      merr_q   <= merr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    f_prev_d = f_prev_q;
    f_cur_d  = f_cur_q;
    ans_d    = ans_q;
    ovf_d    = ovf_q;
    merr_d   = merr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d      = n;
          mode_d   = mode_e'(mode);
          a_d      = coef_a;
          b_d      = coef_b;
          f_prev_d = RES_W'(F0);
          f_cur_d  = RES_W'(F1);
          k_d      = N_W'(2);
          ovf_d    = 1'b0;
          merr_d   = (mode_e'(mode) == MODE_RSVD);
          // n<2 is answered straight from the seeds without entering RUN.
          if ((n >> 1) == '0) begin
            ans_d   = (n == '0) ? RES_W'(F0) : RES_W'(F1);
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        f_prev_d = f_cur_q;
        f_cur_d  = step_f;
        ovf_d    = ovf_q | step_ovf;
        if (k_q == n_q) begin
          ans_d   = step_f;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + N_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign ans      = ans_q;
  assign overflow = ovf_q;
  assign mode_err = merr_q;

endmodule

// File: tb/tb_gen_fib_engine.sv
// Scoreboard bench: a wide-result and an 8-bit-result engine share stimulus; expected
// results are queued at acceptance and compared when done pulses.
`timescale 1ns/1ps
module tb_gen_fib_engine;

  localparam int N_W    = 5;
  localparam int COEF_W = 8;
  localparam int RW_A   = 121;
  localparam int RW_B   = 8;

  logic              clk    = 1'b0;
  logic              reset  = 1'b1;
  logic              start  = 1'b0;
  logic [N_W-1:0]    n      = '0;
  logic [1:0]        mode   = '0;
  logic [COEF_W-1:0] coef_a = '0;
  logic [COEF_W-1:0] coef_b = '0;

  logic              busy_a, done_a, ovf_a, merr_a;
  logic [RW_A-1:0]   ans_a;
  logic              busy_b, done_b, ovf_b, merr_b;
  logic [RW_B-1:0]   ans_b;

  always #5 clk = ~clk;

  gen_fib_engine #(.N_W(N_W), .RES_W(RW_A), .COEF_W(COEF_W)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .n(n), .mode(mode),
    .coef_a(coef_a), .coef_b(coef_b), .busy(busy_a), .done(done_a),
    .ans(ans_a), .overflow(ovf_a), .mode_err(merr_a)
  );

  gen_fib_engine #(.N_W(N_W), .RES_W(RW_B), .COEF_W(COEF_W)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .n(n), .mode(mode),
    .coef_a(coef_a), .coef_b(coef_b), .busy(busy_b), .done(done_b),
    .ans(ans_b), .overflow(ovf_b), .mode_err(merr_b)
  );

  typedef struct {
    logic [255:0] ans_a;
    bit           ovf_a;
    logic [255:0] ans_b;
    bit           ovf_b;
    bit           merr;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           m_cnt = 0;
  int           busy_cnt = 0;
  int           done_prev = 0;
  int           done_last = 0;
  logic [255:0] last_a = '0;
  logic [255:0] last_b = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int nn, input int md, input int ca, input int cb,
                                input int rw, output logic [255:0] res, output bit ov);
    logic [255:0] fp, fc, full, mask;
    int cc, cp;
    mask = (256'd1 << rw) - 256'd1;
    fp = '0;
    fc = 256'd1;
    ov = 1'b0;
    if (nn == 0) res = '0;
    else if (nn == 1) res = 256'd1;
    else begin
      for (int k = 2; k <= nn; k++) begin
        case (md)
          1:       begin cc = k - 1; cp = 1;  end
          2:       begin cc = ca;    cp = cb; end
          default: begin cc = 1;     cp = 1;  end
        endcase
        full = 256'(cc) * fc + 256'(cp) * fp;
        if ((full & ~mask) != '0) ov = 1'b1;
        fp = fc;
        fc = full & mask;
      end
      res = fc;
    end
  endfunction

  // Acceptance model: queue expected results on each edge the engine should take a start.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      sb.delete();
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (start) begin
      exp_t e;
      model(int'(n), int'(mode), int'(coef_a), int'(coef_b), RW_A, e.ans_a, e.ovf_a);
      model(int'(n), int'(mode), int'(coef_a), int'(coef_b), RW_B, e.ans_b, e.ovf_b);
      e.merr    = (mode == 2'd3);
      e.lat     = (n < 2) ? 1 : int'(n);
      e.acc_cyc = cyc;
      sb.push_back(e);
      m_cnt = e.lat;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      last_a   = '0;
      last_b   = '0;
      busy_cnt = 0;
    end else begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 256'(1), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("ans",         256'(ans_a),  e.ans_a);
          chk("overflow",    256'(ovf_a),  256'(e.ovf_a));
          chk("mode_err",    256'(merr_a), 256'(e.merr));
          chk("ans_w8",      256'(ans_b),  e.ans_b);
          chk("overflow_w8", 256'(ovf_b),  256'(e.ovf_b));
          chk("done_w8",     256'(done_b), 256'(1));
          chk("latency",     256'(cyc - e.acc_cyc + 1), 256'(e.lat));
          chk("busy_cycles", 256'(busy_cnt), 256'(e.lat - 1));
        end
        last_a    = 256'(ans_a);
        last_b    = 256'(ans_b);
        busy_cnt  = 0;
        done_prev = done_last;
        done_last = cyc;
      end else begin
        chk("ans_hold",    256'(ans_a), last_a);
        chk("ans_hold_w8", 256'(ans_b), last_b);
      end
    end
  end

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done_a) chk(tag, 256'(0), 256'(1));
  endtask

  task automatic run_op(input int nn, input int md, input int ca, input int cb);
    n      = N_W'(nn);
    mode   = 2'(md);
    coef_a = COEF_W'(ca);
    coef_b = COEF_W'(cb);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("timeout_n%0d_m%0d", nn, md));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",     256'(busy_a), 256'(0));
    chk("rst_done",     256'(done_a), 256'(0));
    chk("rst_ans",      256'(ans_a),  256'(0));
    chk("rst_overflow", 256'(ovf_a),  256'(0));
    chk("rst_mode_err", 256'(merr_a), 256'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 256'(busy_a), 256'(0));
    chk("idle_done", 256'(done_a), 256'(0));

    run_op(10, 0, 0, 0);
    chk("classic_n10", 256'(ans_a), 256'(55));
    run_op(5, 1, 0, 0);
    chk("ext_n5", 256'(ans_a), 256'(43));
    run_op(0, 1, 0, 0);
    chk("ext_n0", 256'(ans_a), 256'(0));
    run_op(1, 1, 0, 0);
    chk("ext_n1", 256'(ans_a), 256'(1));
    run_op(5, 2, 2, 1);
    chk("pell_n5", 256'(ans_a), 256'(29));
    run_op(6, 3, 0, 0);
    chk("rsvd_n6", 256'(ans_a), 256'(8));
    repeat (3) @(negedge clk);
    chk("mode_err_hold", 256'(merr_a), 256'(1));

    run_op(14, 0, 0, 0);
    chk("w8_n14_ans", 256'(ans_b), 256'(121));
    repeat (3) @(negedge clk);
    chk("w8_n14_ovf_hold", 256'(ovf_b), 256'(1));
    run_op(13, 0, 0, 0);
    chk("w8_n13_ans", 256'(ans_b), 256'(233));
    chk("w8_n13_ovf", 256'(ovf_b), 256'(0));
    chk("w8_n13_merr", 256'(merr_b), 256'(0));

    run_op(31, 2, 255, 255);
    chk("gen_max_ovf", 256'(ovf_a), 256'(1));
    run_op(31, 1, 0, 0);

    // Start and new operands during RUN must not disturb the running operation.
    n = 5'd10; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; n = 5'd3; mode = 2'd1; coef_a = 8'd7;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("timeout_handshake");
    chk("handshake_ans", 256'(ans_a), 256'(55));
    @(negedge clk);

    // Start held high: one operation per latency+1 cycles.
    n = 5'd3; mode = 2'd0; start = 1'b1;
    repeat (16) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_spacing", 256'(done_last - done_prev), 256'(4));

    // Reset in the middle of a run.
    n = 5'd10; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 256'(busy_a), 256'(1));
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy",     256'(busy_a), 256'(0));
    chk("midrst_done",     256'(done_a), 256'(0));
    chk("midrst_ans",      256'(ans_a),  256'(0));
    chk("midrst_overflow", 256'(ovf_a),  256'(0));
    chk("midrst_mode_err", 256'(merr_a), 256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run_op(10, 0, 0, 0);
    chk("post_reset_n10", 256'(ans_a), 256'(55));

    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_fib_engine.md
Name: gen_fib_engine

Overview:
- Parametrised iterative linear-recurrence engine. It is the next-generation replacement for the stack-based extended Fibonacci block.
- Computes F(n) using one recurrence step per clock cycle. No stack is used.
- Supports three recurrence modes, configurable index and result widths, and sticky overflow detection.
- Sits behind a start/done handshake, controlled by a host FSM or testbench.

Parameters:
- N_W, 5, width of index input n.
- RES_W, 121, width of result and of internal F registers.
- COEF_W, 8, width of programmable coefficients a and b.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- n  in  N_W  target index; latched on accepted start.
- mode  in  2  recurrence select; latched on accepted start.
- coef_a  in  COEF_W  multiplier a (mode 2); latched on accepted start.
- coef_b  in  COEF_W  multiplier b (mode 2); latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; ans is valid.
- ans  out  RES_W  F(n) mod 2^RES_W; held until next accepted start.
- overflow  out  1  sticky per operation; some step exceeded RES_W bits.
- mode_err  out  1  mode 3 was latched.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, ans=0, overflow=0, mode_err=0; internal k, f_prev, f_cur cleared.
- Seeds: F(0)=0, F(1)=1 in every mode.
- Mode 0 (classic): F(k)=F(k-1)+F(k-2).
- Mode 1 (extended): F(k)=(k-1)*F(k-1)+F(k-2).
- Mode 2 (generalised): F(k)=a*F(k-1)+b*F(k-2).
- Mode 3: reserved; executes as mode 0 and sets mode_err for that operation.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t:
  - latch n, mode, a, b;
  - f_prev=0, f_cur=1, k=2;
  - clear overflow; set mode_err = (mode==3);
  - if n<2, go to DONE; otherwise go to RUN.
- IDLE, start=0: remain in IDLE; all outputs hold.
- RUN, each edge:
  - compute F(k) at full width: RES_W+max(COEF_W,N_W)+1 bits;
  - f_prev<=f_cur; f_cur<=F(k) truncated to RES_W;
  - if any truncated upper bit is nonzero, set overflow (sticky);
  - if k==n, go to DONE; else k<=k+1.
  - RUN therefore lasts exactly n-1 cycles.
- DONE (exactly one cycle):
  - done=1; ans = F(n) (0 for n=0, 1 for n=1, f_cur otherwise);
  - next state is always IDLE.
- Latency from the accepting edge to the done cycle: 1 cycle if n<2; n cycles if n>=2.
- start while in RUN or DONE is ignored. It is not queued. Inputs are not re-sampled.
- Changes on n, mode, or coefficients after acceptance have no effect.
- ans, overflow, and mode_err hold their values after DONE until the next accepted start.
- ans is not cleared on acceptance. It updates only in the DONE cycle.
- Arithmetic is unsigned. The k multiplier in mode 1 is zero-extended from N_W bits.
- Maximum n = 2^N_W - 1. The k counter never wraps, because the k==n exit happens first.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse is produced. A start after reset release is accepted normally.
- start held high continuously: a new operation is accepted in the IDLE cycle after each DONE. Back-to-back throughput is therefore latency+1 cycles.

Decomposition:
- Shared package gen_fib_pkg:
  - mode encodings: MODE_CLASSIC=0, MODE_EXT=1, MODE_GEN=2, MODE_RSVD=3;
  - state encodings for IDLE, RUN, DONE;
  - seed constants F0=0, F1=1.
- One combinational sub-module, fib_step:
  - inputs: f_prev, f_cur, k, mode, a, b;
  - outputs: next F (RES_W bits) and an ovf bit;
  - contains the mul-add and truncation check.
- The FSM, counter, and registers stay in gen_fib_engine.

Test Plan:
- Classic: mode=0, n=10, start pulse → busy high 9 cycles; done at cycle 10; ans=55, overflow=0, mode_err=0.
- Extended: mode=1, n=5 → ans=43 (sequence 0,1,1,3,10,43); done 5 cycles after acceptance. Also n=0 → ans=0 and n=1 → ans=1, each with done 1 cycle after acceptance.
- Generalised: mode=2, a=2, b=1, n=5 → ans=29 (Pell). Mode=3, n=6 → ans=8, mode_err=1.
- Overflow: RES_W=8, mode=0, n=14 → ans=121 (377 mod 256), overflow=1. The next run with n=13 → ans=233, overflow=0 (cleared on accept).
- Handshake: start re-asserted during RUN, and n changed mid-run → ignored; original result delivered. Start held high → consecutive operations spaced latency+1 cycles.
- Reset: assert reset at RUN cycle 3 of an n=10 run → outputs 0 immediately; no done pulse. A fresh n=10 start then yields 55.
